// File: rtl/aes_gate_pkg.sv
// Shared lane function and mode encoding for the pipelined AOI22 gate slice.
// The bit form is used by the RTL; the vector form serves any caller up to LANE_MAX_W lanes.
package aes_gate_pkg;

  localparam logic MODE_AOI   = 1'b0;
  localparam logic MODE_AO    = 1'b1;
  localparam int   LANE_MAX_W = 32;

  // With B = ~g on both B inputs the B-term collapses to ~g.
  function automatic logic aoi22_bit(input logic a1, input logic a2,
                                     input logic g, input logic mode);
    logic f;
    f = (a1 & a2) | ~g;
    return (mode == MODE_AO) ? f : ~f;
  endfunction

  function automatic logic [LANE_MAX_W-1:0] aoi22_lane(input logic [LANE_MAX_W-1:0] a1,
                                                       input logic [LANE_MAX_W-1:0] a2,
                                                       input logic [LANE_MAX_W-1:0] g,
                                                       input logic                  mode);
    logic [LANE_MAX_W-1:0] f;
    f = (a1 & a2) | ~g;
    return (mode == MODE_AO) ? f : ~f;
  endfunction

endpackage

// File: rtl/aoi22_lane_pipe_stage.sv
// One elastic pipeline register: holds a valid bit and a result word.
// up_free is combinational from dn_free so a stalled head still lets bubbles collapse.
module aoi22_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_free,
  output logic             up_free,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;

  always_comb begin
    up_free = ~valid_q | dn_free;
    valid_d = valid_q;
    data_d  = data_q;
    if (up_free) begin
      valid_d = up_valid;
      // Data only moves with a real transaction; empty slots keep stale data.
      if (up_valid) begin
        data_d = up_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/aoi22_lane_pipe.sv
// WIDTH-lane AOI22 (B = ~g) evaluated at capture, carried through a STAGES-deep
// elastic valid/ready pipeline with an occupancy counter.
module aoi22_lane_pipe
  import aes_gate_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int OCC_W  = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a1,
  input  logic [WIDTH-1:0] in_a2,
  input  logic [WIDTH-1:0] in_g,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [OCC_W-1:0] occupancy
);

  logic [WIDTH-1:0]  lane_res;
  logic [STAGES-1:0] st_valid;
  logic [STAGES-1:0] st_free;
  logic [WIDTH-1:0]  st_data [STAGES];
  logic              in_fire;
  logic              out_fire;
  logic [OCC_W-1:0]  occ_q, occ_d;

  always_comb begin
    lane_res = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lane_res[i] = aoi22_bit(in_a1[i], in_a2[i], in_g[i], in_mode);
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;
    logic             dn_f;

    if (i == 0) begin : g_first
      assign up_v = in_valid;
      assign up_d = lane_res;
    end else begin : g_mid
      assign up_v = st_valid[i-1];
      assign up_d = st_data[i-1];
    end

    if (i == STAGES - 1) begin : g_head
      assign dn_f = out_ready;
    end else begin : g_body
      assign dn_f = st_free[i+1];
    end

    aoi22_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (up_v),
      .up_data  (up_d),
      .dn_free  (dn_f),
      .up_free  (st_free[i]),
      .valid    (st_valid[i]),
      .data     (st_data[i])
    );
  end

  assign in_ready  = st_free[0];
  assign out_valid = st_valid[STAGES-1];
  assign out_y     = st_data[STAGES-1];

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    occ_d = occ_q;
    if (in_fire && !out_fire) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!in_fire && out_fire) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_aoi22_lane_pipe.sv
// Self-checking bench for aoi22_lane_pipe: directed scenarios on small configs plus
// a scoreboarded random soak over several WIDTH/STAGES combinations.
module tb_aoi22_lane_pipe;
  import aes_gate_pkg::*;

  localparam int NDUT = 5;

  function automatic int cfg_w(int k);
    case (k)
      0: return 8;
      1: return 8;
      2: return 1;
      3: return 32;
      default: return 13;
    endcase
  endfunction

  function automatic int cfg_s(int k);
    case (k)
      0: return 2;
      1: return 3;
      2: return 1;
      3: return 8;
      default: return 5;
    endcase
  endfunction

  logic            clk;
  logic            rst;
  logic [31:0]     a1, a2, g;
  logic            mode;
  logic [NDUT-1:0] vin, ordy;
  wire  [NDUT-1:0] irdy, ovld;
  wire  [31:0]     yw   [NDUT];
  wire  [3:0]      occw [NDUT];

  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    localparam int CW = cfg_w(k);
    localparam int CS = cfg_s(k);
    localparam int OW = $clog2(CS + 1);
    wire [CW-1:0] y_loc;
    wire [OW-1:0] occ_loc;

    aoi22_lane_pipe #(.WIDTH(CW), .STAGES(CS), .OCC_W(OW)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (vin[k]),
      .in_ready  (irdy[k]),
      .in_a1     (a1[CW-1:0]),
      .in_a2     (a2[CW-1:0]),
      .in_g      (g[CW-1:0]),
      .in_mode   (mode),
      .out_valid (ovld[k]),
      .out_ready (ordy[k]),
      .out_y     (y_loc),
      .occupancy (occ_loc)
    );

    assign yw[k]   = 32'(y_loc);
    assign occw[k] = 4'(occ_loc);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] lane_mask(int k);
    if (cfg_w(k) >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << cfg_w(k)) - 32'd1;
  endfunction

  function automatic logic [31:0] model_y(int k);
    logic [31:0] r;
    r = aoi22_lane(a1, a2, g, mode);
    return r & lane_mask(k);
  endfunction

  function automatic logic [31:0] pat(int j, int salt);
    return (32'(j) * 32'h9E37_79B1) ^ (32'(salt) * 32'h7F4A_7C15) ^ 32'h5A5A_A5A5;
  endfunction

  // Scoreboard: one expected-result queue per DUT, plus occupancy and hold tracking.
  logic [31:0] sb [NDUT][$];
  int          occ_m  [NDUT];
  logic        hold_v [NDUT];
  logic [31:0] hold_y [NDUT];
  logic [31:0] exp_y;
  logic        fin, fout;

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      occ_m[k]  = 0;
      hold_v[k] = 1'b0;
      hold_y[k] = '0;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < NDUT; k++) begin
        checks++;
        if (occw[k] !== 4'(occ_m[k])) begin
          errors++;
          $display("FAIL occupancy dut%0d got %0d want %0d", k, occw[k], occ_m[k]);
        end
        checks++;
        if (irdy[k] !== ((occ_m[k] < cfg_s(k)) || ordy[k])) begin
          errors++;
          $display("FAIL in_ready dut%0d got %b want %b", k, irdy[k],
                   ((occ_m[k] < cfg_s(k)) || ordy[k]));
        end
        if (hold_v[k]) begin
          checks++;
          if (ovld[k] !== 1'b1 || yw[k] !== hold_y[k]) begin
            errors++;
            $display("FAIL stall_hold dut%0d got v=%b y=%h want v=1 y=%h", k, ovld[k], yw[k], hold_y[k]);
          end
        end
        if (ovld[k] === 1'b1) begin
          checks++;
          if (sb[k].size() == 0) begin
            errors++;
            $display("FAIL spurious_out dut%0d got valid y=%h want no output", k, yw[k]);
          end
        end
        if (rst) begin
          sb[k].delete();
          occ_m[k]  = 0;
          hold_v[k] = 1'b0;
        end else begin
          fin  = vin[k] & irdy[k];
          fout = ovld[k] & ordy[k];
          if (fout && sb[k].size() != 0) begin
            exp_y = sb[k].pop_front();
            checks++;
            if (yw[k] !== exp_y) begin
              errors++;
              $display("FAIL data dut%0d got %h want %h", k, yw[k], exp_y);
            end
          end
          if (fin) sb[k].push_back(model_y(k));
          occ_m[k]  = occ_m[k] + int'(fin) - int'(fout);
          hold_v[k] = ovld[k] & ~ordy[k];
          hold_y[k] = yw[k];
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_item(int j);
    a1   = pat(j, 1);
    a2   = pat(j, 2);
    g    = pat(j, 3);
    mode = j[0];
  endtask

  task automatic set_rand();
    a1   = $urandom;
    a2   = $urandom;
    g    = $urandom;
    mode = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (ovld[k] !== 1'b0 || yw[k] !== 32'd0 || occw[k] !== 4'd0 || irdy[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset_state dut%0d got v=%b y=%h occ=%0d rdy=%b want v=0 y=0 occ=0 rdy=1",
                 k, ovld[k], yw[k], occw[k], irdy[k]);
      end
    end
    step();
  endtask

  task automatic test_truth_table();
    logic [7:0] tt;
    logic [7:0] want;
    tt = 8'h2A;
    ordy[0] = 1'b1;
    mode    = MODE_AOI;
    for (int i = 0; i < 8; i++) begin
      a1 = {32{i[2]}};
      a2 = {32{i[1]}};
      g  = {32{i[0]}};
      vin[0] = 1'b1;
      want   = tt[i] ? 8'hFF : 8'h00;
      @(negedge clk);
      checks++;
      if (irdy[0] !== 1'b1) begin
        errors++;
        $display("FAIL tt_accept combo%0d got rdy=%b want 1", i, irdy[0]);
      end
      step();
      vin[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (ovld[0] !== 1'b0) begin
        errors++;
        $display("FAIL tt_early combo%0d got valid=%b want 0", i, ovld[0]);
      end
      step();
      @(negedge clk);
      checks++;
      if (ovld[0] !== 1'b1 || yw[0][7:0] !== want) begin
        errors++;
        $display("FAIL tt_result combo%0d got v=%b y=%h want v=1 y=%h", i, ovld[0], yw[0][7:0], want);
      end
      step();
    end
  endtask

  task automatic test_mode_flip();
    logic [7:0] got [2];
    int n;
    n = 0;
    got[0] = '0;
    got[1] = '0;
    a1 = 32'h0000_00F0;
    a2 = 32'h0000_00CC;
    g  = 32'h0000_00AA;
    mode    = MODE_AOI;
    vin[0]  = 1'b1;
    ordy[0] = 1'b1;
    step();
    mode = MODE_AO;
    step();
    vin[0] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ovld[0] === 1'b1 && n < 2) begin
        got[n] = yw[0][7:0];
        n++;
      end
      step();
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL mode_count got %0d want 2", n);
    end
    checks++;
    if (got[0] !== 8'h2A) begin
      errors++;
      $display("FAIL mode_aoi got %h want 2a", got[0]);
    end
    checks++;
    if (got[1] !== 8'hD5) begin
      errors++;
      $display("FAIL mode_ao got %h want d5", got[1]);
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] r;
    logic [7:0]  exp0;
    int j;
    r    = aoi22_lane(pat(0, 1), pat(0, 2), pat(0, 3), 1'b0);
    exp0 = r[7:0];
    j = 0;
    ordy[0] = 1'b0;
    vin[0]  = 1'b1;
    set_item(j);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (irdy[0] !== (c < 2)) begin
        errors++;
        $display("FAIL bp_ready cycle%0d got %b want %b", c, irdy[0], (c < 2));
      end
      if (c >= 2) begin
        checks++;
        if (occw[0] !== 4'd2 || ovld[0] !== 1'b1 || yw[0][7:0] !== exp0) begin
          errors++;
          $display("FAIL bp_held cycle%0d got occ=%0d v=%b y=%h want occ=2 v=1 y=%h",
                   c, occw[0], ovld[0], yw[0][7:0], exp0);
        end
      end
      if (irdy[0] === 1'b1) j++;
      step();
      set_item(j);
    end
    ordy[0] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (irdy[0] !== 1'b1) begin
        errors++;
        $display("FAIL bp_release cycle%0d got rdy=%b want 1", c, irdy[0]);
      end
      if (irdy[0] === 1'b1) j++;
      step();
      set_item(j);
    end
    vin[0] = 1'b0;
    checks++;
    if (j != 4) begin
      errors++;
      $display("FAIL bp_accepted got %0d want 4", j);
    end
    repeat (6) step();
    @(negedge clk);
    checks++;
    if (occw[0] !== 4'd0 || sb[0].size() != 0) begin
      errors++;
      $display("FAIL bp_drain got occ=%0d pending=%0d want 0 0", occw[0], sb[0].size());
    end
    step();
  endtask

  task automatic test_full_push_pop();
    int nin, nout;
    nin = 0;
    nout = 0;
    ordy[1] = 1'b0;
    vin[1]  = 1'b1;
    set_rand();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (irdy[1] !== 1'b1) begin
        errors++;
        $display("FAIL fill_ready got %b want 1", irdy[1]);
      end
      step();
      set_rand();
    end
    @(negedge clk);
    checks++;
    if (occw[1] !== 4'd3 || irdy[1] !== 1'b0) begin
      errors++;
      $display("FAIL full_state got occ=%0d rdy=%b want occ=3 rdy=0", occw[1], irdy[1]);
    end
    step();
    ordy[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (occw[1] !== 4'd3) begin
        errors++;
        $display("FAIL pushpop_occ cycle%0d got %0d want 3", c, occw[1]);
      end
      if (vin[1] && irdy[1] === 1'b1) nin++;
      if (ovld[1] === 1'b1 && ordy[1]) nout++;
      step();
      set_rand();
    end
    vin[1] = 1'b0;
    checks++;
    if (nin != 10) begin
      errors++;
      $display("FAIL pushpop_in got %0d want 10", nin);
    end
    checks++;
    if (nout != 10) begin
      errors++;
      $display("FAIL pushpop_out got %0d want 10", nout);
    end
    repeat (8) step();
    @(negedge clk);
    checks++;
    if (occw[1] !== 4'd0 || sb[1].size() != 0) begin
      errors++;
      $display("FAIL pushpop_drain got occ=%0d pending=%0d want 0 0", occw[1], sb[1].size());
    end
    step();
  endtask

  task automatic test_reset_mid();
    ordy[0] = 1'b0;
    vin[0]  = 1'b1;
    set_item(10);
    step();
    set_item(11);
    step();
    set_item(12);
    ordy[0] = 1'b1;
    rst = 1'b1;
    step();
    rst     = 1'b0;
    vin[0]  = 1'b0;
    @(negedge clk);
    checks++;
    if (ovld[0] !== 1'b0 || yw[0] !== 32'd0 || occw[0] !== 4'd0 || irdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_state got v=%b y=%h occ=%0d rdy=%b want v=0 y=0 occ=0 rdy=1",
               ovld[0], yw[0], occw[0], irdy[0]);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      @(negedge clk);
      checks++;
      if (ovld[0] !== 1'b0) begin
        errors++;
        $display("FAIL midreset_ghost cycle%0d got valid=%b want 0", c, ovld[0]);
      end
    end
    step();
  endtask

  task automatic test_soak();
    int lim;
    for (int c = 0; c < 10000; c++) begin
      lim = ((c >> 9) & 1) != 0 ? 3 : 1;
      for (int k = 0; k < NDUT; k++) begin
        vin[k]  = ($urandom_range(0, 3) != 0);
        ordy[k] = ($urandom_range(0, 3) >= lim);
      end
      set_rand();
      step();
    end
    vin  = '0;
    ordy = '1;
    repeat (20) step();
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (sb[k].size() != 0 || occw[k] !== 4'd0) begin
        errors++;
        $display("FAIL soak_drain dut%0d got pending=%0d occ=%0d want 0 0", k, sb[k].size(), occw[k]);
      end
    end
    step();
  endtask

  initial begin
    rst  = 1'b1;
    vin  = '0;
    ordy = '0;
    a1   = '0;
    a2   = '0;
    g    = '0;
    mode = MODE_AOI;
    test_reset();
    test_truth_table();
    test_mode_flip();
    test_back_pressure();
    test_full_push_pop();
    test_reset_mid();
    test_soak();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
